// File: rtl/fifo_pkg.sv
// Shared FIFO defaults, default thresholds and the log2 helper for pointer/count widths.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 12;
  localparam int unsigned DEF_DEPTH  = 8;

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_AF_THR = DEF_DEPTH - 2;
  localparam int unsigned DEF_AE_THR = 2;

endpackage

// File: rtl/param_fifo_if.sv
// Handshake and status bundle between a FIFO client (master) and the FIFO (slave).
interface param_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
);
  localparam int unsigned AW = log2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pop;
  logic [CW-1:0]     af_thr;
  logic [CW-1:0]     ae_thr;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              err_ovf;
  logic              err_udf;

  modport master (
    output data_in, push, pop, af_thr, ae_thr, err_clr,
    input  data_out, valid, full, empty, almost_full, almost_empty, count, err_ovf, err_udf
  );

  modport slave (
    input  data_in, push, pop, af_thr, ae_thr, err_clr,
    output data_out, valid, full, empty, almost_full, almost_empty, count, err_ovf, err_udf
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned AW    = log2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is intentionally not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds its value between reads; a same-address write returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with programmable almost-full/empty thresholds and sticky error flags.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  param_fifo_if.slave  bus
);

  localparam int unsigned AW = log2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_udf_q, err_udf_d;
  logic          full_c, empty_c;
  logic          push_ok_c, pop_ok_c;
  logic [DATA_W-1:0] rdata;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign pop_ok_c  = bus.pop && !empty_c;
  assign push_ok_c = bus.push && (!full_c || pop_ok_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    valid_d   = pop_ok_c;
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;

    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new error event outranks a clear arriving in the same cycle.
    if (bus.push && full_c && !bus.pop) err_ovf_d = 1'b1;
    else if (bus.err_clr)               err_ovf_d = 1'b0;

    if (bus.pop && empty_c)  err_udf_d = 1'b1;
    else if (bus.err_clr)    err_udf_d = 1'b0;
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push_ok_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (pop_ok_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign bus.data_out     = rdata;
  assign bus.valid        = valid_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= bus.af_thr);
  assign bus.almost_empty = (count_q <= bus.ae_thr);
  assign bus.count        = count_q;
  assign bus.err_ovf      = err_ovf_q;
  assign bus.err_udf      = err_udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo (DATA_W=12, DEPTH=8, af_thr=6, ae_thr=2).
module tb_param_fifo;
  import fifo_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  param_fifo_if #(.DATA_W(12), .DEPTH(8)) bus ();

  param_fifo #(.DATA_W(12), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply one cycle of push/pop, then sample 1 time unit after the edge.
  task automatic cyc(input logic ps, input logic pp, input logic [11:0] d);
    bus.push    = ps;
    bus.pop     = pp;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    bus.err_clr = 1'b0;
    bus.af_thr  = 4'(DEF_AF_THR);
    bus.ae_thr  = 4'(DEF_AE_THR);
    cyc(1'b0, 1'b0, 12'h0);
    cyc(1'b1, 1'b1, 12'h5A5);
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'd0);
    chk("rst_errs", 32'({bus.err_ovf, bus.err_udf}), 32'd0);

    // Basic push/pop with 1-cycle read latency
    cyc(1'b1, 1'b0, 12'h00A);
    chk("b_cnt1", 32'(bus.count), 32'd1);
    chk("b_valid_push", 32'(bus.valid), 32'd0);
    cyc(1'b1, 1'b0, 12'h00B);
    chk("b_cnt2", 32'(bus.count), 32'd2);
    cyc(1'b0, 1'b1, 12'h0);
    chk("b_v1", 32'(bus.valid), 32'd1);
    chk("b_d1", 32'(bus.data_out), 32'h00A);
    chk("b_cnt3", 32'(bus.count), 32'd1);
    cyc(1'b0, 1'b1, 12'h0);
    chk("b_v2", 32'(bus.valid), 32'd1);
    chk("b_d2", 32'(bus.data_out), 32'h00B);
    chk("b_empty", 32'(bus.empty), 32'd1);
    cyc(1'b0, 1'b0, 12'h0);
    chk("b_v_idle", 32'(bus.valid), 32'd0);
    chk("b_d_hold", 32'(bus.data_out), 32'h00B);

    // Fill to full, overflow, drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 12'(32'h100 + i));
      chk("f_cnt", 32'(bus.count), 32'(i + 1));
      chk("f_af", 32'(bus.almost_full), 32'((i + 1) >= 6));
      chk("f_ae", 32'(bus.almost_empty), 32'((i + 1) <= 2));
      chk("f_full", 32'(bus.full), 32'((i + 1) == 8));
    end
    chk("f_ovf_pre", 32'(bus.err_ovf), 32'd0);
    cyc(1'b1, 1'b0, 12'h1FF);
    chk("f_ovf", 32'(bus.err_ovf), 32'd1);
    chk("f_cnt_ovf", 32'(bus.count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 12'h0);
      chk("f_pop_v", 32'(bus.valid), 32'd1);
      chk("f_pop_d", 32'(bus.data_out), 32'h100 + 32'(i));
      chk("f_pop_cnt", 32'(bus.count), 32'(7 - i));
    end
    chk("f_empty", 32'(bus.empty), 32'd1);
    chk("f_ovf_sticky", 32'(bus.err_ovf), 32'd1);
    bus.err_clr = 1'b1;
    cyc(1'b0, 1'b0, 12'h0);
    bus.err_clr = 1'b0;
    chk("f_ovf_clr", 32'(bus.err_ovf), 32'd0);

    // Pointer wrap: 3 rounds of 5 in / 5 out
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 12'(32'h200 + 16 * r + k));
      chk("w_cnt5", 32'(bus.count), 32'd5);
      for (int k = 0; k < 5; k++) begin
        cyc(1'b0, 1'b1, 12'h0);
        chk("w_d", 32'(bus.data_out), 32'h200 + 32'(16 * r + k));
      end
      chk("w_cnt0", 32'(bus.count), 32'd0);
    end

    // Simultaneous push/pop when full, then when empty
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 12'(32'h300 + i));
    chk("s_full", 32'(bus.full), 32'd1);
    cyc(1'b1, 1'b1, 12'h3AA);
    chk("s_cnt8", 32'(bus.count), 32'd8);
    chk("s_v", 32'(bus.valid), 32'd1);
    chk("s_d", 32'(bus.data_out), 32'h300);
    chk("s_no_ovf", 32'(bus.err_ovf), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 12'h0);
      chk("s_drain", 32'(bus.data_out), 32'h301 + 32'(i));
    end
    cyc(1'b0, 1'b1, 12'h0);
    chk("s_last", 32'(bus.data_out), 32'h3AA);
    chk("s_empty", 32'(bus.empty), 32'd1);
    cyc(1'b1, 1'b1, 12'h0CC);
    chk("s_udf", 32'(bus.err_udf), 32'd1);
    chk("s_cnt1", 32'(bus.count), 32'd1);
    chk("s_v0", 32'(bus.valid), 32'd0);
    chk("s_d_hold", 32'(bus.data_out), 32'h3AA);

    // Error event coinciding with clear keeps the flag; clear alone drops it
    cyc(1'b0, 1'b1, 12'h0);
    chk("e_d", 32'(bus.data_out), 32'h0CC);
    bus.err_clr = 1'b1;
    cyc(1'b0, 1'b1, 12'h0);
    chk("e_set_clr", 32'(bus.err_udf), 32'd1);
    chk("e_v0", 32'(bus.valid), 32'd0);
    cyc(1'b0, 1'b0, 12'h0);
    bus.err_clr = 1'b0;
    chk("e_clr", 32'(bus.err_udf), 32'd0);

    // Threshold changes are seen combinationally
    bus.af_thr = 4'd0;
    #1;
    chk("t_af0", 32'(bus.almost_full), 32'd1);
    bus.af_thr = 4'(DEF_AF_THR);
    bus.ae_thr = 4'd0;
    cyc(1'b1, 1'b0, 12'h0DD);
    chk("t_ae0", 32'(bus.almost_empty), 32'd0);
    bus.ae_thr = 4'(DEF_AE_THR);
    #1;
    chk("t_ae2", 32'(bus.almost_empty), 32'd1);
    cyc(1'b0, 1'b1, 12'h0);
    chk("t_d", 32'(bus.data_out), 32'h0DD);

    // Mid-operation reset during a push
    cyc(1'b0, 1'b1, 12'h0);
    chk("r_udf", 32'(bus.err_udf), 32'd1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 12'(32'h400 + k));
    chk("r_cnt5", 32'(bus.count), 32'd5);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 12'h4FF);
    reset = 1'b0;
    chk("r_cnt0", 32'(bus.count), 32'd0);
    chk("r_empty", 32'(bus.empty), 32'd1);
    chk("r_valid", 32'(bus.valid), 32'd0);
    chk("r_errs", 32'({bus.err_ovf, bus.err_udf}), 32'd0);
    chk("r_dout", 32'(bus.data_out), 32'd0);
    cyc(1'b1, 1'b0, 12'h777);
    cyc(1'b0, 1'b1, 12'h0);
    chk("r_post_d", 32'(bus.data_out), 32'h777);
    chk("r_post_cnt", 32'(bus.count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 12, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, 4 or more.
REQ-003 Derived constants: AW = log2(DEPTH); CW = AW+1 (count and threshold width).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 data_in  in  DATA_W  write data, sampled when push is accepted.
REQ-007 push  in  1  write request.
REQ-008 pop  in  1  read request.
REQ-009 af_thr  in  CW  almost-full threshold, runtime programmable.
REQ-010 ae_thr  in  CW  almost-empty threshold, runtime programmable.
REQ-011 err_clr  in  1  clears the sticky error flags.
REQ-012 data_out  out  DATA_W  registered read data.
REQ-013 valid  out  1  one-cycle strobe qualifying data_out.
REQ-014 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-015 count  out  CW  current occupancy, 0..DEPTH.
REQ-016 err_ovf, err_udf  out  1 each  sticky overflow and underflow flags.

Function
REQ-017 A push is accepted when !full, or when full and a pop is accepted in the same cycle; the entry is written at mem[wr_ptr], then wr_ptr increments.
REQ-018 A pop is accepted when !empty; in the next cycle data_out = mem[rd_ptr] and valid = 1; rd_ptr increments. Read latency is 1 cycle.
REQ-019 valid is 0 in any cycle not following an accepted pop; data_out holds its last value when valid = 0.
REQ-020 Pointers are AW bits wide and wrap modulo DEPTH with no gap or skipped entry.
REQ-021 count updates as +1 (push only), -1 (pop only), or unchanged (both or neither); it never exceeds DEPTH and never goes below 0.
REQ-022 full = (count == DEPTH); empty = (count == 0); both are derived from the registered count.
REQ-023 almost_full = (count >= af_thr); almost_empty = (count <= ae_thr); threshold changes take effect in the same cycle.
REQ-024 Push while full with no pop: data is dropped, state is unchanged, and err_ovf sets on the next edge.
REQ-025 Pop while empty: ignored, valid stays 0, and err_udf sets; a simultaneous push is still accepted (no bypass).
REQ-026 err_ovf and err_udf stay set until err_clr = 1; if an error event coincides with err_clr, the flag is set.

Reset
REQ-027 Reset is synchronous and active-high; it dominates push, pop, and err_clr.
REQ-028 On reset: wr_ptr = 0, rd_ptr = 0, count = 0, data_out = 0, valid = 0, err_ovf = 0, err_udf = 0; hence empty = 1, full = 0, almost_empty = 1, almost_full = (af_thr == 0).
REQ-029 Memory contents are not cleared; reset asserted mid-operation discards all entries.

Structure
REQ-030 Shared package fifo_pkg holds the default DATA_W and DEPTH, the log2 helper used for AW and CW, and the default thresholds (AF = DEPTH-2, AE = 2).
REQ-031 Storage is a sub-module fifo_mem: DEPTH x DATA_W register array with one synchronous write port and one registered read port.
REQ-032 Pointer, count, flag, and error logic reside in param_fifo.

Verification (DATA_W = 12, DEPTH = 8, af_thr = 6, ae_thr = 2)
REQ-033 Reset, then push 0x00A and 0x00B, then pop twice -> valid on the cycle after each pop; data 0x00A then 0x00B; count 2 -> 0; empty = 1 at end.
REQ-034 Push 8 words 0x100..0x107 -> almost_full rises at count 6; full at count 8; a ninth push 0x1FF is dropped and err_ovf = 1; 8 pops return 0x100..0x107.
REQ-035 Wrap: push 5 and pop 5, three times with distinct data -> data order preserved across pointer wrap; count ends at 0.
REQ-036 Full FIFO with push and pop in the same cycle -> count stays 8, the oldest word is output, and the new word is stored last; empty FIFO with push and pop -> err_udf = 1 and count = 1.
REQ-037 Error set together with err_clr -> flag remains 1; err_clr alone on the next cycle -> flag becomes 0.
REQ-038 Reset asserted at count 5 during a push -> the next cycle shows count = 0, empty = 1, valid = 0, and errors = 0.
